// File: rtl/uart_tx_sched_if.sv
// Request/transmitter handshake bundle for the uart_tx_sched round-robin scheduler.
// The slave side is the scheduler; the master side is requesters plus the transmitter.
interface uart_tx_sched_if #(
   parameter int NREQ = 8
);
   logic [NREQ-1:0] req;
   logic            dir_rx;
   logic            err_clr;
   logic            rq;
   logic [4:0]      cycle;
   logic            busy;
   logic            done;
   logic [4:0]      done_id;
   logic            err_timeout;

   modport master (
      output req, dir_rx, err_clr,
      input  rq, cycle, busy, done, done_id, err_timeout
   );

   modport slave (
      input  req, dir_rx, err_clr,
      output rq, cycle, busy, done, done_id, err_timeout
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler driving the RS-485 burst transmitter RQ/cycle pair.
// Tracks each burst through dirRX, enforces a release gap and a watchdog abort.
module uart_tx_sched #(
   parameter int NREQ    = 8,
   parameter int GAP     = 4,
   parameter int TIMEOUT = 1023
) (
   input logic            clk,
   input logic            reset,
   uart_tx_sched_if.slave bus
);

   localparam int          IDW      = $clog2(NREQ);
   localparam int          GW       = $clog2(GAP);
   localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [2:0] {
      s_idle,
      s_arb,
      s_req,
      s_xfer,
      s_rel
   } state_t;

   state_t          state;
   logic [1:0]      dsync_q;
   logic            dsync;
   logic [NREQ-1:0] pending;
   logic [NREQ-1:0] clr_mask;
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  win_idx;
   logic            win_found;
   logic [15:0]     wdog;
   logic [GW-1:0]   gap;
   logic            abort;

   logic            rq;
   logic [4:0]      cycle;
   logic            busy;
   logic            done;
   logic [4:0]      done_id;
   logic            err_timeout;

   // NOTE: every clocked block uses non-blocking assignments so all flops
   // sample the pre-edge values; reset is asynchronous, active-low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dsync_q <= '0;
      end else begin
         dsync_q <= {dsync_q[0], bus.dir_rx};
      end
   end

   assign dsync = dsync_q[1];

   // NOTE: combinational outputs get a default before any branch so no latch
   // is inferred when the loop finds nothing.
   always_comb begin : arbiter
      int             idx;
      logic [IDW-1:0] idx_l;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      idx_l     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx   = (int'(last) + k) % NREQ;
         idx_l = IDW'(idx);
         if (!win_found && pending[idx_l]) begin
            win_found = 1'b1;
            win_idx   = idx_l;
         end
      end
   end

   assign clr_mask = (state == s_arb && win_found) ?
                     ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;

   // Watchdog expires only while still waiting for the expected dirRX edge.
   assign abort = (wdog == WD_LAST) &&
                  ((state == s_req && !dsync) || (state == s_xfer && dsync));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= s_idle;
         pending     <= '0;
         last        <= IDW'(NREQ - 1);
         wdog        <= '0;
         gap         <= '0;
         rq          <= 1'b0;
         cycle       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_id     <= '0;
         err_timeout <= 1'b0;
      end else begin
         done    <= 1'b0;
         pending <= (pending & ~clr_mask) | bus.req;

         // The abort branch below assigns later, so a new timeout beats err_clr.
         if (bus.err_clr) begin
            err_timeout <= 1'b0;
         end

         if (abort) begin
            rq          <= 1'b0;
            err_timeout <= 1'b1;
            done_id     <= cycle;
            gap         <= '0;
            state       <= s_rel;
         end else begin
            case (state)
               s_idle: begin
                  if (|pending) begin
                     busy  <= 1'b1;
                     state <= s_arb;
                  end
               end
               s_arb: begin
                  if (win_found) begin
                     last  <= win_idx;
                     cycle <= 5'(win_idx);
                     rq    <= 1'b1;
                     wdog  <= '0;
                     state <= s_req;
                  end else begin
                     busy  <= 1'b0;
                     state <= s_idle;
                  end
               end
               s_req: begin
                  if (dsync) begin
                     wdog  <= '0;
                     state <= s_xfer;
                  end else begin
                     wdog <= wdog + 16'd1;
                  end
               end
               s_xfer: begin
                  if (!dsync) begin
                     rq      <= 1'b0;
                     done    <= 1'b1;
                     done_id <= cycle;
                     gap     <= '0;
                     state   <= s_rel;
                  end else begin
                     wdog <= wdog + 16'd1;
                  end
               end
               s_rel: begin
                  // Hold at the last gap count until the transmitter lets dirRX go.
                  if (gap == GAP_LAST) begin
                     if (!dsync) begin
                        gap   <= '0;
                        busy  <= 1'b0;
                        state <= s_idle;
                     end
                  end else begin
                     gap <= gap + GW'(1);
                  end
               end
               default: begin
                  rq    <= 1'b0;
                  busy  <= 1'b0;
                  state <= s_idle;
               end
            endcase
         end
      end
   end

   assign bus.rq          = rq;
   assign bus.cycle       = cycle;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.done_id     = done_id;
   assign bus.err_timeout = err_timeout;

endmodule
